// File: rtl/fir_param.sv
// Parametrised direct-form FIR, run-time coefficient port, saturating output.
// Define FIR_PIPE_EN to register the tap products (latency 2 instead of 1).
module fir_param #(
  parameter int NB    = 11,
  parameter int NTAPS = 11,
  parameter int AW    = 6
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 CLR,
  input  logic signed [NB-1:0] DIN,
  input  logic                 VIN,
  input  logic                 COEF_WE,
  input  logic [AW-1:0]        COEF_ADDR,
  input  logic signed [NB-1:0] COEF_DATA,
  output logic signed [NB-1:0] DOUT,
  output logic                 VOUT
);

  localparam int PW   = 2 * NB;
  localparam int ACCW = PW + $clog2(NTAPS);

  localparam logic signed [ACCW-1:0] MAXV =
    ACCW'((64'sd1 <<< (NB - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] MINV = -MAXV - 1;

  logic signed [NB-1:0]   x [NTAPS];
  logic signed [NB-1:0]   h [NTAPS];
  logic signed [PW-1:0]   prod [NTAPS];
  logic signed [PW-1:0]   term [NTAPS];
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] y;
  logic signed [NB-1:0]   sat;
  logic                   v_s;
  logic                   v_o;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NTAPS; i++) x[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < NTAPS; i++) x[i] <= '0;
    end else if (VIN) begin
      x[0] <= DIN;
      for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
    end
  end

  // Out-of-range addresses simply match no tap.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NTAPS; i++) h[i] <= '0;
    end else if (COEF_WE) begin
      for (int i = 0; i < NTAPS; i++)
        if (COEF_ADDR == AW'(i)) h[i] <= COEF_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) v_s <= 1'b0;
    else        v_s <= VIN & ~CLR;
  end

  always_comb begin
    for (int i = 0; i < NTAPS; i++) prod[i] = x[i] * h[i];
  end

`ifdef FIR_PIPE_EN
  logic signed [PW-1:0] p_q [NTAPS];
  logic                 v_p;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      v_p <= 1'b0;
      for (int i = 0; i < NTAPS; i++) p_q[i] <= '0;
    end else begin
      v_p <= v_s & ~CLR;
      if (v_s && !CLR)
        for (int i = 0; i < NTAPS; i++) p_q[i] <= prod[i];
    end
  end

  assign term = p_q;
  assign v_o  = v_p;
`else
  assign term = prod;
  assign v_o  = v_s;
`endif

  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAPS; i++)
      acc = acc + {{(ACCW-PW){term[i][PW-1]}}, term[i]};
  end

  assign y = acc >>> (NB - 1);

  always_comb begin
    sat = y[NB-1:0];
    if (y > MAXV)      sat = MAXV[NB-1:0];
    else if (y < MINV) sat = MINV[NB-1:0];
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      DOUT <= '0;
      VOUT <= 1'b0;
    end else begin
      VOUT <= v_o & ~CLR;
      if (v_o && !CLR) DOUT <= sat;
    end
  end

endmodule

// File: tb/tb_fir_param.sv
// Directed-vector bench for fir_param (NB=11, NTAPS=11).
// Latency follows FIR_PIPE_EN.
module tb_fir_param;

`ifdef FIR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               CLK = 1'b0;
  logic               RST_n = 1'b0;
  logic               CLR = 1'b0;
  logic signed [10:0] DIN = '0;
  logic               VIN = 1'b0;
  logic               COEF_WE = 1'b0;
  logic [5:0]         COEF_ADDR = '0;
  logic signed [10:0] COEF_DATA = '0;
  logic signed [10:0] DOUT;
  logic               VOUT;

  fir_param #(.NB(11), .NTAPS(11), .AW(6)) dut (
    .CLK(CLK), .RST_n(RST_n), .CLR(CLR),
    .DIN(DIN), .VIN(VIN),
    .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR),
    .COEF_DATA(COEF_DATA),
    .DOUT(DOUT), .VOUT(VOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit                 vin;
    bit                 clr;
    bit                 we;
    logic [5:0]         addr;
    logic signed [10:0] din;
    logic signed [10:0] cd;
    int                 ed;
  } vec_t;

  vec_t tv[$];
  int   errors = 0;
  int   checks = 0;
  int   last   = 0;

  function automatic vec_t mk(input bit vin, input int din,
                              input int ed, input bit clr = 1'b0,
                              input bit we = 1'b0, input int addr = 0,
                              input int cd = 0);
    vec_t v;
    v.vin  = vin;
    v.din  = 11'(din);
    v.ed   = ed;
    v.clr  = clr;
    v.we   = we;
    v.addr = 6'(addr);
    v.cd   = 11'(cd);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int addr, input int val);
    COEF_WE   = 1'b1;
    COEF_ADDR = 6'(addr);
    COEF_DATA = 11'(val);
    @(posedge CLK); #1;
    COEF_WE   = 1'b0;
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
  endtask

  // Apply tv; output of row r is expected LAT edges after its capture.
  task automatic run(input string nm);
    int n;
    bit killed[];
    bit ev;
    int idx;
    n = tv.size();
    killed = new[n];
    for (int j = 0; j < n + LAT; j++) begin
      if (j < n) begin
        VIN = tv[j].vin; DIN = tv[j].din; CLR = tv[j].clr;
        COEF_WE = tv[j].we; COEF_ADDR = tv[j].addr;
        COEF_DATA = tv[j].cd;
      end else begin
        VIN = 1'b0; DIN = '0; CLR = 1'b0; COEF_WE = 1'b0;
      end
      @(posedge CLK); #1;
      if (j < n && tv[j].clr)
        for (int k = j - LAT; k <= j; k++)
          if (k >= 0) killed[k] = 1'b1;
      idx = j - LAT;
      ev = idx >= 0 && idx < n && tv[idx].vin && !killed[idx];
      if (ev) last = tv[idx].ed;
      chk($sformatf("%s vout[%0d]", nm, j), int'(VOUT), int'(ev));
      chk($sformatf("%s dout[%0d]", nm, j), int'(DOUT), last);
    end
    VIN = 1'b0; CLR = 1'b0; COEF_WE = 1'b0;
    tv.delete();
  endtask

  task automatic push_impulse(input bit gaps, input bit zero);
    for (int i = 0; i < 12; i++) begin
      tv.push_back(mk(1'b1, i == 0 ? 512 : 0,
                      (zero || i == 11) ? 0 : 32 * (i + 1)));
      if (gaps) tv.push_back(mk(1'b0, 0, 0));
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset dout", int'(DOUT), 0);
    chk("reset vout", int'(VOUT), 0);
    @(negedge CLK) RST_n = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 11; i++) load(i, 64 * (i + 1));
    push_impulse(1'b0, 1'b0);
    run("impulse");

    push_impulse(1'b1, 1'b0);
    run("gaps");

    load(11, 500);
    push_impulse(1'b0, 1'b0);
    run("addr11");

    tv.push_back(mk(1'b1, 512, 32));
    tv.push_back(mk(1'b1, 0, 64));
    tv.push_back(mk(1'b1, 0, 96));
    tv.push_back(mk(1'b1, 0, 128));
    tv.push_back(mk(1'b1, 512, 0, 1'b1));
    push_impulse(1'b0, 1'b0);
    run("clr");

    tv.push_back(mk(1'b1, 512, 128, 1'b0, 1'b1, 0, 256));
    run("wr+vin");

    for (int i = 0; i < 11; i++) load(i, 1023);
    clr_pulse();
    for (int i = 0; i < 11; i++)
      tv.push_back(mk(1'b1, 1023, i == 0 ? 1022 : 1023));
    run("possat");

    clr_pulse();
    for (int i = 0; i < 11; i++)
      tv.push_back(mk(1'b1, -1024, i == 0 ? -1023 : -1024));
    run("negsat");

    VIN = 1'b1; DIN = 11'sd500;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_n = 1'b0;
    #1;
    chk("async rst dout", int'(DOUT), 0);
    chk("async rst vout", int'(VOUT), 0);
    VIN = 1'b0;
    @(posedge CLK);
    @(negedge CLK) RST_n = 1'b1;
    last = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge CLK); #1;
      chk("post rst vout", int'(VOUT), 0);
    end
    push_impulse(1'b0, 1'b1);
    run("h cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
